playwav: RTL and testbench
==========================

Name: playwav

Overview:
- Transmit-side counterpart of the frame capture stage in MFC_REC.
- Accepts one packed frame of FRAME_LEN signed 16-bit samples in a single handshake.
- Replays the frame as a paced sample stream with a per-sample data-valid strobe.
- Feeds a downstream sample consumer, or drives the capture path in loopback benches.

Parameters:
- FRAME_LEN, 160, samples per frame; 2..255.
- SAMPLE_W, 16, bits per sample, signed.
- DIV, 1, clocks between successive dv_out pulses; 1..65535; 1 = one sample per clock.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- frame_valid  input  1  frame_in holds a complete frame.
- frame_in  input  FRAME_LEN*SAMPLE_W  packed frame; sample k = frame_in[k*SAMPLE_W +: SAMPLE_W].
- frame_ready  output  1  frame accepted on an edge where frame_valid && frame_ready.
- dv_out  output  1  out holds a valid sample; one-cycle pulse per sample.
- out  output  SAMPLE_W  signed sample, registered.
- last  output  1  high with dv_out on sample FRAME_LEN-1 only.
- busy  output  1  high in STREAM.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE; dv_out=0, out=0, last=0, busy=0; idx=0, cnt=0, pre-emphasis history=0.
  - Partial frame discarded; no further dv_out until a new frame is accepted.
- States: IDLE, STREAM.
- Counters: cnt is the pacing counter, 0..DIV-1, wraps; tick = (state==STREAM && cnt==0). idx is the sample index, 0..FRAME_LEN-1.
- frame_ready (combinational from registers) = (state==IDLE) || (tick && idx==FRAME_LEN-1).
- Accept from IDLE: latch frame_in into frame buffer; idx<=0, cnt<=0, state<=STREAM. First dv_out is registered at the next edge (1-cycle latency).
- Each clock in STREAM: cnt <= (cnt==DIV-1) ? 0 : cnt+1.
- On tick edge:
  - out<=sample[idx] (or filtered value, see Optional Feature); dv_out<=1; last<=(idx==FRAME_LEN-1).
  - If idx<FRAME_LEN-1: idx<=idx+1.
- Non-tick edges: dv_out<=0, last<=0; out holds its value.
- End of frame (tick with idx==FRAME_LEN-1):
  - If accept also occurs on this edge: reload buffer, idx<=0, stay STREAM. cnt continues its normal increment, so back-to-back frames keep exactly DIV-clock spacing (DIV=1 gives a gapless stream).
  - Otherwise: state<=IDLE.
- frame_valid while frame_ready=0 is ignored; the buffer is never overwritten mid-frame. frame_in is sampled only on the accept edge.
- busy=1 from the edge after accept through the edge that emits the last sample, when no back-to-back accept occurs.

Optional Feature:
- Macro: PLAYWAV_PREEMPH_EN.
- Defined: out = sat16(x[n] - (x[n-1] - (x[n-1]>>>5))), i.e. pre-emphasis coefficient 31/32.
  - Computed at 18 bits signed, saturated to [-32768, 32767].
  - x[n-1] is the previous raw emitted sample. History carries across frames, is updated only on tick, and is cleared by reset.
- Undefined: out = x[n] raw; no history register.

Test Plan:
- DIV=1, frame sample k=k (0..159), frame_valid held 1 cycle in IDLE:
  - 160 consecutive dv_out pulses starting 1 cycle after accept.
  - out=0..159; last only with out=159; then busy=0, frame_ready=1.
- DIV=4, same frame:
  - dv_out exactly every 4th clock; 160 pulses in 637 clocks from first pulse; out sequence unchanged.
- DIV=1, frame_valid held high with frame A (all 0x1111) then frame B (all 0x2222) presented at the last tick of A:
  - 320 consecutive pulses; sample 159=0x1111, sample 160=0x2222.
  - last pulses twice; busy never drops.
- Mid-frame frame_valid with a different frame_in after sample 20 (frame_ready=0):
  - ignored; remaining samples come from the original frame.
- rst asserted asynchronously after sample 50:
  - dv_out/out/last/busy = 0 immediately, frame_ready=1.
  - A new frame then restarts from sample 0.
- PLAYWAV_PREEMPH_EN, frame of constant 32: out[0]=32, out[1..159]=1.
- PLAYWAV_PREEMPH_EN, samples -32768 then 32767: second output saturates to 32767.

Source files
------------

// File: rtl/playwav.sv
// playwav: replays one packed frame as a paced sample stream with dv/last strobes.
// Define PLAYWAV_PREEMPH_EN to add a 31/32 pre-emphasis filter on the output.
module playwav #(
  parameter int FRAME_LEN = 160,
  parameter int SAMPLE_W  = 16,
  parameter int DIV       = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_valid,
  input  logic [FRAME_LEN*SAMPLE_W-1:0] frame_in,
  output logic                          frame_ready,
  output logic                          dv_out,
  output logic signed [SAMPLE_W-1:0]    out,
  output logic                          last,
  output logic                          busy
);

  localparam int FW = FRAME_LEN * SAMPLE_W;
  localparam logic [7:0] IDX_END = 8'(FRAME_LEN - 1);
  localparam logic [15:0] CNT_END = 16'(DIV - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [FW-1:0] buf_q;
  logic signed [SAMPLE_W-1:0] out_q, out_d;
  logic dv_q, dv_d;
  logic last_q, last_d;
  logic load;
  logic tick;
  logic at_end;
  logic signed [SAMPLE_W-1:0] sample;
  logic signed [SAMPLE_W-1:0] emit;

  assign tick   = (state_q == STREAM) && (cnt_q == '0);
  assign at_end = (idx_q == IDX_END);
  assign sample = buf_q[int'(idx_q) * SAMPLE_W +: SAMPLE_W];

`ifdef PLAYWAV_PREEMPH_EN
  localparam int EW = SAMPLE_W + 2;
  localparam logic signed [EW-1:0] SMAX = {3'b000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {3'b111, {(SAMPLE_W-1){1'b0}}};

  logic signed [SAMPLE_W-1:0] hist_q, hist_d;
  logic signed [EW-1:0] x_e, h_e, y_e;

  // y = x[n] - 31/32 * x[n-1], widened so the difference cannot wrap
  assign x_e = {{2{sample[SAMPLE_W-1]}}, sample};
  assign h_e = {{2{hist_q[SAMPLE_W-1]}}, hist_q};
  assign y_e = x_e - (h_e - (h_e >>> 5));
  assign emit = (y_e > SMAX) ? SMAX[SAMPLE_W-1:0] :
                (y_e < SMIN) ? SMIN[SAMPLE_W-1:0] :
                y_e[SAMPLE_W-1:0];
`else
  assign emit = sample;
`endif

  assign frame_ready = (state_q == IDLE) || (tick && at_end);
  assign busy        = (state_q == STREAM);
  assign dv_out      = dv_q;
  assign out         = out_q;
  assign last        = last_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    dv_d    = 1'b0;
    last_d  = 1'b0;
    load    = 1'b0;
`ifdef PLAYWAV_PREEMPH_EN
    hist_d  = hist_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (frame_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        cnt_d = (cnt_q == CNT_END) ? '0 : cnt_q + 16'd1;
        if (tick) begin
          out_d  = emit;
          dv_d   = 1'b1;
          last_d = at_end;
`ifdef PLAYWAV_PREEMPH_EN
          hist_d = sample;
`endif
          // a new frame taken on the final tick keeps the pacing unbroken
          if (!at_end) begin
            idx_d = idx_q + 8'd1;
          end else if (frame_valid) begin
            load  = 1'b1;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
`ifdef PLAYWAV_PREEMPH_EN
      hist_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
`ifdef PLAYWAV_PREEMPH_EN
      hist_q  <= hist_d;
`endif
    end
  end

  // frame storage needs no reset: it is only read after a load
  always_ff @(posedge clk) begin
    if (load) begin
      buf_q <= frame_in;
    end
  end

endmodule

// File: tb/tb_playwav.sv
// Scoreboard bench for playwav: two instances (DIV=1 and DIV=4) run in parallel
// against a timeline model of when each sample must appear.
module tb_playwav;

  localparam int FL = 160;
  localparam int SW = 16;
  localparam int FW = FL * SW;

  typedef struct {
    int at;
    int val;
    bit lst;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int model_out(input int x, input int h);
`ifdef PLAYWAV_PREEMPH_EN
    int y;
    int hi;
    int lo;
    hi = (1 << (SW - 1)) - 1;
    lo = -(1 << (SW - 1));
    y = x - (h - (h >>> 5));
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y;
`else
    return x + 0 * h;
`endif
  endfunction

  function automatic logic [FW-1:0] ramp();
    logic [FW-1:0] f;
    for (int k = 0; k < FL; k++) f[k*SW +: SW] = SW'(k);
    return f;
  endfunction

  function automatic logic [FW-1:0] fill(input logic [SW-1:0] v);
    logic [FW-1:0] f;
    for (int k = 0; k < FL; k++) f[k*SW +: SW] = v;
    return f;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int D = (gi == 0) ? 1 : 4;
    localparam int BUD = 400 * D + 50;

    logic rst;
    logic fv;
    logic [FW-1:0] fin;
    logic fr;
    logic dv;
    logic signed [SW-1:0] o;
    logic lst;
    logic bsy;

    exp_t q[$];
    int cyc = 0;
    int last_at = -1;
    int hist = 0;
    int acc = 0;
    int emitted = 0;
    bit done = 1'b0;

    playwav #(
      .FRAME_LEN(FL),
      .SAMPLE_W (SW),
      .DIV      (D)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_valid(fv),
      .frame_in   (fin),
      .frame_ready(fr),
      .dv_out     (dv),
      .out        (o),
      .last       (lst),
      .busy       (bsy)
    );

    // Model: a frame is taken whenever the previous one has no sample left
    // to emit before this edge; its samples land DIV edges apart.
    initial begin
      int first;
      int x;
      exp_t e;
      forever begin
        @(posedge clk);
        cyc++;
        if (rst === 1'b0 && fv === 1'b1 && cyc >= last_at) begin
          first = (cyc == last_at) ? cyc + D : cyc + 1;
          for (int k = 0; k < FL; k++) begin
            x = int'($signed(fin[k*SW +: SW]));
            e.at = first + k * D;
            e.val = model_out(x, hist);
            e.lst = (k == FL - 1);
            q.push_back(e);
            hist = x;
          end
          last_at = first + (FL - 1) * D;
          acc++;
        end
      end
    end

    initial begin
      forever begin
        @(posedge rst);
        q.delete();
        last_at = -1;
        hist = 0;
      end
    end

    initial begin
      bit e_dv;
      forever begin
        @(negedge clk);
        e_dv = (q.size() > 0) && (q[0].at == cyc);
        chk($sformatf("div%0d dv", D), int'(dv), int'(e_dv));
        if (e_dv) begin
          chk($sformatf("div%0d out#%0d", D, emitted), int'(o), q[0].val);
          chk($sformatf("div%0d last#%0d", D, emitted), int'(lst), int'(q[0].lst));
          void'(q.pop_front());
          emitted++;
        end
        chk($sformatf("div%0d busy", D), int'(bsy), int'(cyc < last_at));
        chk($sformatf("div%0d ready", D), int'(fr), int'(cyc + 1 >= last_at));
      end
    end

    task automatic wait_acc(input int target);
      int n;
      n = 0;
      while (acc < target && n < BUD) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("div%0d accept_wait", D), int'(acc >= target), 1);
    endtask

    task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() > 0 || cyc < last_at) && n < BUD) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("div%0d idle_wait", D), int'(q.size() == 0 && cyc >= last_at), 1);
    endtask

    task automatic wait_emit(input int target);
      int n;
      n = 0;
      while (emitted < target && n < BUD) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("div%0d emit_wait", D), int'(emitted >= target), 1);
    endtask

    task automatic send(input logic [FW-1:0] f);
      int a0;
      a0 = acc;
      @(negedge clk);
      fin = f;
      fv = 1'b1;
      wait_acc(a0 + 1);
      fv = 1'b0;
    endtask

    task automatic rst_pulse();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    endtask

    initial begin
      int a0;
      int e0;
      logic [FW-1:0] f;
      rst = 1'b1;
      fv = 1'b0;
      fin = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      send(ramp());
      wait_idle();

      a0 = acc;
      @(negedge clk);
      fin = fill(16'h1111);
      fv = 1'b1;
      wait_acc(a0 + 1);
      fin = fill(16'h2222);
      wait_acc(a0 + 2);
      fv = 1'b0;
      wait_idle();

      e0 = emitted;
      send(ramp());
      wait_emit(e0 + 21);
      fin = fill(16'h5555);
      fv = 1'b1;
      repeat (10) @(negedge clk);
      fv = 1'b0;
      wait_idle();

      e0 = emitted;
      send(ramp());
      wait_emit(e0 + 51);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk($sformatf("div%0d rst_dv", D), int'(dv), 0);
      chk($sformatf("div%0d rst_out", D), int'(o), 0);
      chk($sformatf("div%0d rst_last", D), int'(lst), 0);
      chk($sformatf("div%0d rst_busy", D), int'(bsy), 0);
      chk($sformatf("div%0d rst_ready", D), int'(fr), 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      send(ramp());
      wait_idle();

      repeat (FL * D * 3) begin
        @(negedge clk);
        fv = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < FL; k++) fin[k*SW +: SW] = SW'($urandom);
      end
      @(negedge clk);
      fv = 1'b0;
      wait_idle();

      rst_pulse();
      send(fill(16'd32));
      wait_idle();

      rst_pulse();
      f = '0;
      f[0 +: SW] = 16'h8000;
      f[SW +: SW] = 16'h7fff;
      send(f);
      wait_idle();

      done = 1'b1;
    end
  end

  initial begin
    fork
      wait (g[0].done && g[1].done);
      begin
        repeat (40000) @(posedge clk);
        total++;
        bad++;
        $display("FAIL watchdog actual=timeout required=both_done");
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
